// File: rtl/tcb_gpio_pkg.sv
// Shared widths and per-bit configuration type for the GPIO input-conditioning stage.
package tcb_gpio_pkg;

    localparam int unsigned GPIO_GW = 32;  // GPIO bits
    localparam int unsigned GPIO_SW = 2;   // synchroniser depth (two flops minimum)
    localparam int unsigned GPIO_PW = 16;  // prescaler counter width
    localparam int unsigned GPIO_NW = 4;   // debounce counter width

    // Per-bit interrupt enables, grouped so the top can hand one bundle to each slice.
    typedef struct packed {
        logic rie;  // interrupt on stable 0->1
        logic fie;  // interrupt on stable 1->0
    } gpio_bit_cfg_t;

endpackage

// File: rtl/tcb_gpio_debounce_bit.sv
// One GPIO input slice: synchroniser, debounce counter, stable level,
// rise/fall event pulses and a sticky pending flag.
module tcb_gpio_debounce_bit
    import tcb_gpio_pkg::*;
#(
    parameter int unsigned SW = GPIO_SW,
    parameter int unsigned NW = GPIO_NW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pad_i,
    input  logic          tick,
    input  logic [NW-1:0] cfg_thr,
    input  gpio_bit_cfg_t cfg,
    input  logic          irq_clr,
    output logic          gpio_o,
    output logic          evt_rise_o,
    output logic          evt_fall_o,
    output logic          irq_pnd_o
);

    logic [SW-1:0] sync_q, sync_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          pnd_q, pnd_d;
    logic          s;

    assign s = sync_q[SW-1];

    // Next state: shift the synchroniser, count stable ticks, commit the new level.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        sync_d = {sync_q[SW-2:0], pad_i};
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == lvl_q) begin
            cnt_d = '0;  // input agrees with the stable level: any glitch restarts here
        end else if (tick) begin
            if (cnt_q != cfg_thr) begin
                cnt_d = cnt_q + NW'(1);
            end else begin
                lvl_d  = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end
        end
        // A new enabled event outranks a clear arriving in the same cycle.
        pnd_d = (pnd_q & ~irq_clr) | (rise_q & cfg.rie) | (fall_q & cfg.fie);
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            pnd_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pnd_q  <= pnd_d;
        end
    end

    assign gpio_o     = lvl_q;
    assign evt_rise_o = rise_q;
    assign evt_fall_o = fall_q;
    assign irq_pnd_o  = pnd_q;

endmodule

// File: rtl/tcb_gpio_debounce.sv
// GPIO input conditioning: shared prescaler, GW debounce slices and the OR-ed interrupt.
module tcb_gpio_debounce
    import tcb_gpio_pkg::*;
#(
    parameter int unsigned GW = GPIO_GW,
    parameter int unsigned SW = GPIO_SW,
    parameter int unsigned PW = GPIO_PW,
    parameter int unsigned NW = GPIO_NW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [GW-1:0] pad_i,
    input  logic [PW-1:0] cfg_div,
    input  logic [NW-1:0] cfg_thr,
    input  logic [GW-1:0] cfg_rie,
    input  logic [GW-1:0] cfg_fie,
    input  logic [GW-1:0] irq_clr,
    output logic [GW-1:0] gpio_i,
    output logic [GW-1:0] evt_rise,
    output logic [GW-1:0] evt_fall,
    output logic [GW-1:0] irq_pnd,
    output logic          irq
);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    // Prescaler next state: tick on the terminal count, then restart from zero.
    // If cfg_div drops below the running count the compare misses and the
    // counter simply rolls over at 2^PW before lining up again.
    always_comb begin
        tick  = (pre_q == cfg_div);
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
    end

    gpio_bit_cfg_t [GW-1:0] bit_cfg;

    for (genvar i = 0; i < GW; i++) begin : g_bit
        assign bit_cfg[i] = '{rie: cfg_rie[i], fie: cfg_fie[i]};

        tcb_gpio_debounce_bit #(
            .SW (SW),
            .NW (NW)
        ) u_bit (
            .clk        (clk),
            .rst        (rst),
            .pad_i      (pad_i[i]),
            .tick       (tick),
            .cfg_thr    (cfg_thr),
            .cfg        (bit_cfg[i]),
            .irq_clr    (irq_clr[i]),
            .gpio_o     (gpio_i[i]),
            .evt_rise_o (evt_rise[i]),
            .evt_fall_o (evt_fall[i]),
            .irq_pnd_o  (irq_pnd[i])
        );
    end

    // OR of registered flags only, so the CPU line cannot glitch.
    assign irq = |irq_pnd;

endmodule

// File: tb/tb_tcb_gpio_debounce.sv
// Directed and randomised checks of the GPIO debounce stage.
module tb_tcb_gpio_debounce;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pad_i;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_thr;
    logic [31:0] cfg_rie, cfg_fie, irq_clr;
    logic [31:0] gpio_i, evt_rise, evt_fall, irq_pnd;
    logic        irq;

    int errors = 0;
    int checks = 0;

    tcb_gpio_debounce #(
        .GW (32), .SW (2), .PW (16), .NW (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pad_i    (pad_i),
        .cfg_div  (cfg_div),
        .cfg_thr  (cfg_thr),
        .cfg_rie  (cfg_rie),
        .cfg_fie  (cfg_fie),
        .irq_clr  (irq_clr),
        .gpio_i   (gpio_i),
        .evt_rise (evt_rise),
        .evt_fall (evt_fall),
        .irq_pnd  (irq_pnd),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gpio"}, gpio_i, 32'h0);
        check({tag, ".rise"}, evt_rise, 32'h0);
        check({tag, ".fall"}, evt_fall, 32'h0);
        check({tag, ".pnd"}, irq_pnd, 32'h0);
        check({tag, ".irq"}, {31'b0, irq}, 32'h0);
    endtask

    // Reference model state (SW=2)
    logic [31:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_pnd;
    logic [3:0]  m_cnt [32];
    logic [15:0] m_pre;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_pnd = '0;
        m_pre = '0;
        for (int i = 0; i < 32; i++) m_cnt[i] = '0;
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        logic        t;
        logic [31:0] n_lvl, n_rise, n_fall;
        t = (m_pre == cfg_div);
        n_lvl = m_lvl; n_rise = '0; n_fall = '0;
        for (int i = 0; i < 32; i++) begin
            if (m_s2[i] == m_lvl[i]) m_cnt[i] = 4'd0;
            else if (t && m_cnt[i] == cfg_thr) begin
                m_cnt[i] = 4'd0;
                n_lvl[i] = m_s2[i];
                if (m_s2[i]) n_rise[i] = 1'b1;
                else         n_fall[i] = 1'b1;
            end else if (t) m_cnt[i] = m_cnt[i] + 4'd1;
        end
        m_pnd  = (m_pnd & ~irq_clr) | (m_rise & cfg_rie) | (m_fall & cfg_fie);
        m_lvl  = n_lvl;
        m_rise = n_rise;
        m_fall = n_fall;
        m_pre  = t ? 16'd0 : m_pre + 16'd1;
        m_s2   = m_s1;
        m_s1   = pad_i;
    endtask

    initial begin
        // ---- reset state and first debounce after release ----
        rst = 1'b1; pad_i = 32'h0000_0001; cfg_div = 16'd0; cfg_thr = 4'd3;
        cfg_rie = '0; cfg_fie = '0; irq_clr = '0;
        cyc(2);
        check_all_zero("reset");
        rst = 1'b0;
        cyc(5);
        check("rel.gpio_before", gpio_i, 32'h0);
        cyc(1);
        check("rel.gpio_at6", gpio_i, 32'h1);
        check("rel.rise_at6", evt_rise, 32'h1);
        cyc(1);
        check("rel.rise_gone", evt_rise, 32'h0);
        check("rel.pnd_disabled", irq_pnd, 32'h0);

        // ---- glitch shorter than cfg_thr+1 ticks is rejected ----
        cfg_rie = 32'h0000_0020;
        pad_i = 32'h0000_0021;
        cyc(3);
        pad_i = 32'h0000_0001;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            check("glitch.gpio", gpio_i, 32'h1);
            check("glitch.rise", evt_rise, 32'h0);
        end
        check("glitch.pnd", irq_pnd, 32'h0);

        // ---- prescaler: cfg_div=9, cfg_thr=1, phase fixed by a reset ----
        rst = 1'b1; pad_i = 32'h0000_0004; cfg_div = 16'd9; cfg_thr = 4'd1; cfg_rie = '0;
        cyc(2);
        rst = 1'b0;
        cyc(19);
        check("pre.gpio_early", gpio_i, 32'h0);
        cyc(1);
        check("pre.gpio_at20", gpio_i, 32'h4);
        check("pre.rise_at20", evt_rise, 32'h4);

        // ---- interrupt pending: rise enabled, fall disabled ----
        rst = 1'b1; pad_i = '0; cfg_div = 16'd0; cfg_thr = 4'd3;
        cfg_rie = 32'h0000_0008; cfg_fie = '0;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        pad_i = 32'h0000_0008;
        cyc(6);
        check("irq.rise1", evt_rise, 32'h8);
        check("irq.pnd_not_yet", irq_pnd, 32'h0);
        cyc(1);
        check("irq.pnd_set", irq_pnd, 32'h8);
        check("irq.line_set", {31'b0, irq}, 32'h1);
        irq_clr = 32'h0000_0008;
        cyc(1);
        irq_clr = '0;
        check("irq.pnd_cleared", irq_pnd, 32'h0);
        check("irq.line_cleared", {31'b0, irq}, 32'h0);
        pad_i = '0;
        cyc(6);
        check("irq.fall_evt", evt_fall, 32'h8);
        cyc(1);
        check("irq.fall_no_pnd", irq_pnd, 32'h0);
        pad_i = 32'h0000_0008;
        cyc(6);
        check("irq.rise2", evt_rise, 32'h8);
        irq_clr = 32'h0000_0008;
        cyc(1);
        irq_clr = '0;
        check("irq.set_wins", irq_pnd, 32'h8);
        cyc(1);
        irq_clr = 32'h0000_0008;
        cyc(1);
        irq_clr = '0;
        check("irq.lone_clr", irq_pnd, 32'h0);

        // ---- fall enabled, then disabled: flag stays pending ----
        cfg_fie = 32'h0000_0008;
        pad_i = 32'h0000_0001;
        cyc(6);
        check("dis.fall3", evt_fall, 32'h8);
        check("dis.rise0", evt_rise, 32'h1);
        cyc(1);
        check("dis.pnd", irq_pnd, 32'h8);
        cfg_fie = '0;
        cyc(1);
        check("dis.pnd_kept", irq_pnd, 32'h8);

        // ---- async reset mid-debounce and mid-pending ----
        pad_i = 32'h0000_0081;
        cyc(4);
        check("ar.gpio_pre", gpio_i, 32'h1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        cyc(1);
        rst = 1'b0;
        cyc(5);
        check("ar.gpio_early", gpio_i, 32'h0);
        cyc(1);
        check("ar.gpio_at6", gpio_i, 32'h81);
        check("ar.rise_at6", evt_rise, 32'h81);

        // ---- random toggling against the reference model ----
        rst = 1'b1; pad_i = '0; cfg_div = 16'd1; cfg_thr = 4'd1;
        cfg_rie = $urandom; cfg_fie = $urandom; irq_clr = '0;
        model_reset();
        cyc(2);
        rst = 1'b0;
        for (int k = 0; k < 400; k++) begin
            check("rnd.gpio", gpio_i, m_lvl);
            check("rnd.rise", evt_rise, m_rise);
            check("rnd.fall", evt_fall, m_fall);
            check("rnd.pnd", irq_pnd, m_pnd);
            check("rnd.irq", {31'b0, irq}, {31'b0, |m_pnd});
            pad_i   = pad_i ^ ($urandom & $urandom & $urandom);
            irq_clr = $urandom & $urandom & $urandom & $urandom;
            model_step();
            cyc(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
